// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the RAM arbiter and the RAM it fronts: port indices,
// default geometry and the lock-owner state encoding.
package ram_arbiter_pkg;

    localparam int PORT_CORE          = 0;
    localparam int PORT_LOADER        = 1;
    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_ADDR_SPACE = 16;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED0  = 2'd1,
        LOCKED1  = 2'd2
    } lock_state_t;

endpackage

// File: rtl/ram_arbiter_grant.sv
// arb2_grant: one-hot grant decision for two requesters, honouring an active lock.
// Conflict policy selected by RAM_ARBITER_ROUND_ROBIN_EN (round-robin) or fixed port-0 priority.
module arb2_grant (
    input  logic       req0,
    input  logic       req1,
    input  logic       last_gnt,
    input  logic       lock_valid,
    input  logic       lock_owner,
    output logic [1:0] gnt
);

    logic w_conflict_to1;
    logic w_owner_req;

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    // The port that was not served last wins a conflict.
    assign w_conflict_to1 = ~last_gnt;
`else
    logic w_unused_last_gnt;
    assign w_unused_last_gnt = last_gnt;
    assign w_conflict_to1    = 1'b0;
`endif

    assign w_owner_req = lock_owner ? req1 : req0;

    // A lock only blocks the other port while its owner keeps requesting.
    always_comb begin
        gnt = 2'b00;
        if (lock_valid && w_owner_req) begin
            gnt = lock_owner ? 2'b10 : 2'b01;
        end else if (req0 && req1) begin
            gnt = w_conflict_to1 ? 2'b10 : 2'b01;
        end else begin
            gnt = {req1, req0};
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter driving a single-port RAM with combinational read data.
// Optional build macro: RAM_ARBITER_ROUND_ROBIN_EN (round-robin conflicts; default fixed priority).
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_SPACE = DEFAULT_ADDR_SPACE
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_SPACE-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic                  lock0,
    output logic                  gnt0,
    output logic                  rvalid0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_SPACE-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    input  logic                  lock1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [ADDR_SPACE-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_wren,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    logic [1:0]            w_req;
    logic [1:0]            w_we;
    logic [1:0]            w_lock;
    logic [1:0]            w_gnt_arb;
    logic [1:0]            w_gnt;
    logic                  w_last_gnt;
    logic                  w_lock_valid;
    logic                  w_lock_owner;
    logic                  w_rvalid [2];
    logic [DATA_WIDTH-1:0] w_rdata  [2];
    lock_state_t           r_lock_state;

    assign w_req  = {req1, req0};
    assign w_we   = {we1, we0};
    assign w_lock = {lock1, lock0};

    assign w_lock_valid = (r_lock_state != UNLOCKED);
    assign w_lock_owner = (r_lock_state == LOCKED1);

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    logic r_last_gnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_gnt <= 1'b1;
        end else if (|w_gnt) begin
            r_last_gnt <= w_gnt[1];
        end
    end

    assign w_last_gnt = r_last_gnt;
`else
    assign w_last_gnt = 1'b1;
`endif

    arb2_grant u_grant (
        .req0       (w_req[0]),
        .req1       (w_req[1]),
        .last_gnt   (w_last_gnt),
        .lock_valid (w_lock_valid),
        .lock_owner (w_lock_owner),
        .gnt        (w_gnt_arb)
    );

    // Reset masks grants combinationally so nothing reaches the RAM in a reset cycle.
    assign w_gnt = reset ? 2'b00 : w_gnt_arb;
    assign gnt0  = w_gnt[0];
    assign gnt1  = w_gnt[1];

    assign ram_address = w_gnt[1] ? addr1 : addr0;
    assign ram_data    = w_gnt[0] ? wdata0 : (w_gnt[1] ? wdata1 : '0);
    assign ram_wren    = |(w_gnt & w_we);

    // Lock follows the most recent grant; an owner dropping req releases it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_lock_state <= UNLOCKED;
        end else if (w_gnt[1]) begin
            r_lock_state <= w_lock[1] ? LOCKED1 : UNLOCKED;
        end else if (w_gnt[0]) begin
            r_lock_state <= w_lock[0] ? LOCKED0 : UNLOCKED;
        end else if (w_lock_valid && !w_req[w_lock_owner]) begin
            r_lock_state <= UNLOCKED;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            logic                  r_rvalid;
            logic [DATA_WIDTH-1:0] r_rdata;

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_rvalid <= 1'b0;
                    r_rdata  <= '0;
                end else begin
                    r_rvalid <= w_gnt[gi] & ~w_we[gi];
                    if (w_gnt[gi] && !w_we[gi]) begin
                        r_rdata <= ram_q;
                    end
                end
            end

            // A result pending when reset rises is dropped in that same cycle.
            assign w_rvalid[gi] = r_rvalid & ~reset;
            assign w_rdata[gi]  = r_rdata;
        end
    endgenerate

    assign rvalid0 = w_rvalid[PORT_CORE];
    assign rvalid1 = w_rvalid[PORT_LOADER];
    assign rdata0  = w_rdata[PORT_CORE];
    assign rdata1  = w_rdata[PORT_LOADER];

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM plus a transaction-level reference model,
// directed scenarios followed by randomized traffic.
module tb_ram_arbiter;

    localparam int DW = 16;
    localparam int AW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          req0, we0, lock0, req1, we1, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data;
    logic          ram_wren;
    logic [DW-1:0] ram_q;

    always #5 clock = ~clock;

    ram_arbiter #(.DATA_WIDTH(DW), .ADDR_SPACE(AW)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
        .ram_q(ram_q)
    );

    // Behavioural single-port RAM: combinational read, write at the clock edge.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clock) if (ram_wren) mem[ram_address] <= ram_data;
    assign ram_q = mem[ram_address];

    // Reference model state
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            lock_owner;
    int            last_win;
    bit            exp_rvalid [2];
    logic [DW-1:0] exp_rdata  [2];
    int            last_w;
    int            cyc;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic set_port(input int p, input bit r, input bit w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input bit l);
        if (p == 0) begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d; lock0 = l;
        end else begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d; lock1 = l;
        end
    endtask

    function automatic bit port_req(input int p);
        return (p == 0) ? req0 : req1;
    endfunction

    // Who should win this cycle, from the arbitration rules alone.
    function automatic int exp_winner();
        if (reset) return -1;
        if (lock_owner >= 0 && port_req(lock_owner)) return lock_owner;
        if (req0 && req1) begin
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
            return 1 - last_win;
`else
            return 0;
`endif
        end
        if (req0) return 0;
        if (req1) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        lock_owner = -1;
        last_win   = 1;
        exp_rvalid = '{0, 0};
        exp_rdata  = '{'0, '0};
    endtask

    // One clock cycle: check outputs mid-cycle, advance the model, move to the next cycle.
    task automatic step();
        int            w;
        bit            wr, lk;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            nv [2];
        @(negedge clock);
        w  = exp_winner();
        wr = (w == 0) ? we0 : ((w == 1) ? we1 : 1'b0);
        lk = (w == 0) ? lock0 : ((w == 1) ? lock1 : 1'b0);
        a  = (w == 1) ? addr1 : addr0;
        d  = (w == 0) ? wdata0 : ((w == 1) ? wdata1 : '0);
        check_val("gnt0", {31'd0, gnt0}, {31'd0, w == 0});
        check_val("gnt1", {31'd0, gnt1}, {31'd0, w == 1});
        check_val("ram_wren", {31'd0, ram_wren}, {31'd0, wr});
        check_val("ram_address", {16'd0, ram_address}, {16'd0, a});
        check_val("ram_data", {16'd0, ram_data}, {16'd0, d});
        check_val("rvalid0", {31'd0, rvalid0}, {31'd0, exp_rvalid[0] && !reset});
        check_val("rvalid1", {31'd0, rvalid1}, {31'd0, exp_rvalid[1] && !reset});
        check_val("rdata0", {16'd0, rdata0}, {16'd0, exp_rdata[0]});
        check_val("rdata1", {16'd0, rdata1}, {16'd0, exp_rdata[1]});
        last_w = w;
        if (reset) begin
            model_reset();
            $display("cyc %0d reset", cyc);
        end else begin
            nv = '{0, 0};
            if (w >= 0) begin
                last_win = w;
                if (wr) begin
                    ref_mem[a] = d;
                end else begin
                    nv[w]        = 1;
                    exp_rdata[w] = ref_mem[a];
                end
                lock_owner = lk ? w : -1;
                $display("cyc %0d port%0d %s addr=%h data=%h lock=%0d", cyc, w,
                         wr ? "write" : "read ", a, wr ? d : ref_mem[a], lk);
            end else if (lock_owner >= 0 && !port_req(lock_owner)) begin
                lock_owner = -1;
            end
            exp_rvalid = nv;
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    bit pend [2];
    bit lk_bit;

    initial begin
        cyc = 0;
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        set_port(0, 0, 0, '0, '0, 0);
        set_port(1, 0, 0, '0, '0, 0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        model_reset();

        // Reset held three cycles with both ports trying to write.
        set_port(0, 1, 1, 16'h0040, 16'h1234, 0);
        set_port(1, 1, 1, 16'h0040, 16'h5678, 0);
        for (int i = 0; i < 3; i++) step();
        check_val("reset_mem_untouched", {16'd0, mem[16'h0040]}, 32'd0);
        reset = 1'b0;
        set_port(0, 0, 0, '0, '0, 0);
        set_port(1, 0, 0, '0, '0, 0);

        // Write then read back on port 0.
        set_port(0, 1, 1, 16'h0010, 16'hBEEF, 0);
        step();
        set_port(0, 1, 0, 16'h0010, '0, 0);
        step();
        set_port(0, 0, 0, '0, '0, 0);
        step();
        check_val("wr_rd_rdata0", {16'd0, rdata0}, 32'h0000BEEF);

        // Four cycles of conflicting reads straight after reset.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_port(0, 1, 0, 16'h0010, '0, 0);
            set_port(1, 1, 0, 16'h0011, '0, 0);
            step();
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
            check_val("conflict_winner", last_w, i % 2);
`else
            check_val("conflict_winner", last_w, 0);
`endif
        end

        // Locked read-modify-write by port 0 while port 1 waits on the same word.
        set_port(1, 1, 0, 16'h0020, '0, 0);
        set_port(0, 1, 0, 16'h0020, '0, 1);
        step();
        check_val("lock_first", last_w, 0);
        set_port(0, 1, 1, 16'h0020, 16'hA5A5, 0);
        step();
        check_val("lock_second", last_w, 0);
        set_port(0, 0, 0, '0, '0, 0);
        step();
        check_val("lock_third", last_w, 1);
        set_port(1, 0, 0, '0, '0, 0);
        step();
        check_val("lock_rdata1", {16'd0, rdata1}, 32'h0000A5A5);

        // Reset arriving the cycle after a port 1 read grant.
        set_port(1, 1, 0, 16'h0020, '0, 0);
        step();
        set_port(1, 0, 0, '0, '0, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_port(0, 1, 0, 16'h0010, '0, 0);
        set_port(1, 1, 0, 16'h0020, '0, 0);
        step();
        check_val("post_reset_conflict", last_w, 0);
        set_port(0, 0, 0, '0, '0, 0);
        set_port(1, 0, 0, '0, '0, 0);
        step();

        // Randomized traffic: each requester holds its request until granted.
        pend = '{0, 0};
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p]) begin
                    if ($urandom_range(0, 9) < 7) begin
                        pend[p] = 1;
                        lk_bit  = (p == 0) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 19) == 0);
                        set_port(p, 1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)),
                                 16'($urandom), lk_bit);
                    end else begin
                        set_port(p, 0, 0, 16'($urandom_range(0, 15)), '0, 0);
                    end
                end
            end
            reset = ($urandom_range(0, 49) == 0);
            step();
            if (last_w >= 0) pend[last_w] = 0;
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

- Two-requester arbiter in front of the single-port RAM; shares one `address`/`data`/`wren` port between the CPU core (port 0) and the loader/DMA engine (port 1).
- Both requesters use a req/gnt handshake.
- RAM reads are combinational, so read data is captured in a per-port register and returned one cycle after grant.
- Sits directly upstream of the RAM and drives all of its inputs.

## Interface
Parameters:
- DATA_WIDTH, 16, RAM word width
- ADDR_SPACE, 16, RAM address width (2^ADDR_SPACE words)

Ports (x = 0, 1):
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- reqx  in  1  port x requests an access
- wex  in  1  1 = write, 0 = read; valid with reqx
- addrx  in  ADDR_SPACE  word address
- wdatax  in  DATA_WIDTH  write data
- lockx  in  1  hold the grant for port x's next access
- gntx  out  1  access accepted this cycle (combinational)
- rvalidx  out  1  rdatax holds read result (one-cycle pulse)
- rdatax  out  DATA_WIDTH  registered read data
- ram_address  out  ADDR_SPACE  to RAM `address`
- ram_data  out  DATA_WIDTH  to RAM `data`
- ram_wren  out  1  to RAM `wren`
- ram_q  in  DATA_WIDTH  from RAM `q` (combinational read)

## Operation
- **Requester rule.** A requester holds req, we, addr and wdata stable until gnt is seen high; gnt high completes the transfer.
- **Grants per cycle.** At most one grant per cycle.
  - Only one port requesting: that port is granted.
  - Both requesting: the policy port wins (see Configuration).
- **Driving the RAM.** The granted port's addr/wdata go to ram_address/ram_data. ram_wren = gnt & we of that port.
  - With no grant: ram_address = addr0, ram_data = 0, ram_wren = 0.
- **Reads.** When a read is granted, ram_q is registered into rdatax and rvalidx = 1 on the next cycle. rdatax holds its value until the next read on that port.
- **Lock.** If a port is granted with lockx = 1, lock_owner = x is set.
  - While lock_owner is valid, only that port may be granted; the other port waits.
  - Lock clears on the owner's first grant with lockx = 0, or on any cycle the owner does not request.
  - Lock is used for read-modify-write by the core.
- **State:** last_gnt (1 b), lock_valid, lock_owner, rdata0/1, rvalid0/1.

## Timing
- **Reset values** (registers, applied at the clocking edge with reset = 1):
  - rvalid0/1 = 0, rdata0/1 = 0
  - last_gnt = 1, so port 0 wins the first conflict
  - lock_valid = 0
- **While reset is high:** gnt0/1 = 0 and ram_wren = 0 (combinationally masked).
- **Write latency:** the RAM is updated at the edge ending the grant cycle.
- **Read latency:** grant in cycle N, rvalid/rdata in cycle N+1.
- **Throughput:** back-to-back grants to the same or alternating ports every cycle; no bubbles.
- **Read after write, same address:**
  - Write granted in N, read granted in N+1: returns the new data.
  - The other port cannot see a write in the same cycle it happens (only one grant per cycle).
- **Reset mid-operation:** a pending rvalid is dropped, lock is released, and no RAM write occurs in the reset cycle.
- **Lock boundary:** a locked port deasserting req releases the lock in that same cycle, so the other port can be granted that cycle.

## Configuration
- Macro `RAM_ARBITER_ROUND_ROBIN_EN`.
  - **Defined:** on conflict, the port not in last_gnt wins; last_gnt updates on every grant.
  - **Undefined:** fixed priority, port 0 always wins conflicts; last_gnt is not implemented.
- Lock behaviour is identical in both builds.

## Structure
- **Shared package/header:** port index constants PORT_CORE = 0 and PORT_LOADER = 1, plus default DATA_WIDTH/ADDR_SPACE values shared with the RAM.
- **Sub-module:** one natural sub-module, `arb2_grant`.
  - Inputs: req0, req1, last_gnt, lock_valid, lock_owner.
  - Outputs: one-hot gnt.
  - Contains the macro-selected policy.
- **Top level:** muxing, read registers and lock FSM (states UNLOCKED, LOCKED0, LOCKED1).

## Test plan
- **Reset:** assert reset 3 cycles while req0 = req1 = 1 with we = 1 -> gnt = 0, ram_wren = 0, rvalid = 0, rdata = 0; memory is unchanged.
- **Write then read:**
  - Port 0 writes 0xBEEF to 0x0010, then reads 0x0010 in the next cycle.
  - Expect rvalid0 = 1 and rdata0 = 0xBEEF one cycle after the read grant.
- **Conflict, round-robin build:** both ports request reads for 4 cycles -> grants 0,1,0,1.
- **Conflict, fixed-priority build:** same stimulus -> grants 0,0,0,0 and port 1 is starved.
- **Lock:**
  - Port 0 reads 0x0020 with lock = 1 while port 1 requests continuously.
  - Next cycle port 0 writes 0x0020 with lock = 0.
  - Expect port 1 granted only in the third cycle, and a port 1 read of 0x0020 returning port 0's write value.
- **Reset mid-read:** port 1 read granted in cycle N, reset high in N+1 -> rvalid1 = 0 in N+1; first conflict after reset is won by port 0.
